// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared types and default sizing for the FFT sample feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } fft_state_t;

    localparam int FFT_DW       = 8;
    localparam int FFT_N_POINTS = 1024;
    localparam int FFT_IDX_W    = 10;

endpackage
`default_nettype wire

// File: rtl/sample_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sample_tick_gen
//  Description : Rising-edge detector for the divided sample clock. Emits a
//                one-cycle tick in the clk domain per sample_clk rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_clk,
    output logic tick
);

    logic sclk_d;

    // Previous-cycle copy of sample_clk for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d <= 1'b0;
        end else begin
            sclk_d <= sample_clk;
        end
    end

    // Only the low-to-high transition produces a tick.
    assign tick = sample_clk & ~sclk_d;

endmodule
`default_nettype wire

// File: rtl/fft_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : fft_sample_feeder
//  Description : Captures one ADC word per sample_clk rising edge and streams
//                frames of N_POINTS samples into the FFT sink with
//                valid/ready/sop/eop. Single-shot or continuous framing.
//                Optional macro FFT_FEEDER_SIGNED_EN converts offset-binary
//                ADC words to two's complement (MSB inversion).
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_sample_feeder
    import fft_pkg::*;
#(
    parameter int DW       = FFT_DW,
    parameter int N_POINTS = FFT_N_POINTS,
    parameter int IDX_W    = FFT_IDX_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_clk,
    input  logic [DW-1:0] adc_data,
    input  logic          start,
    input  logic          cont_mode,
    input  logic          fft_ready,
    output logic          fft_valid,
    output logic          fft_sop,
    output logic          fft_eop,
    output logic [DW-1:0] fft_data,
    output logic          busy,
    output logic          overrun,
    output logic          frame_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

    fft_state_t       state;
    fft_state_t       state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [DW-1:0]    conv_data;
    logic             tick;
    logic             active;
    logic             accept;
    logic             last_accept;
    logic             stop;
    logic             capture;
    logic             drop;
    logic             start_ok;

    sample_tick_gen u_tick_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_clk (sample_clk),
        .tick       (tick)
    );

`ifdef FFT_FEEDER_SIGNED_EN
    assign conv_data = {~adc_data[DW-1], adc_data[DW-2:0]};
`else
    assign conv_data = adc_data;
`endif

    // idx is the frame position of the next sample to be delivered; an
    // accepted beat in this cycle means a same-cycle capture is one further on.
    assign active      = (state != IDLE);
    assign accept      = fft_valid & fft_ready;
    assign last_accept = accept & fft_eop;
    assign stop        = last_accept & ~cont_mode;
    assign idx_nxt     = accept ? idx + 1'b1 : idx;
    assign start_ok    = (state == IDLE) & start;
    // A single-shot frame ends on its eop beat, so no new sample is taken then.
    assign capture     = active & tick & (~fft_valid | accept) & ~stop;
    assign drop        = active & tick & fft_valid & ~accept;
    assign busy        = active;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARM;
            ARM:     if (tick)  state_nxt = RUN;
            RUN:     if (stop)  state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    // Output register, frame index, sticky overrun and frame_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fft_valid  <= 1'b0;
            fft_sop    <= 1'b0;
            fft_eop    <= 1'b0;
            fft_data   <= '0;
            idx        <= '0;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (capture) begin
                fft_valid <= 1'b1;
                fft_data  <= conv_data;
                fft_sop   <= (idx_nxt == '0);
                fft_eop   <= (idx_nxt == LAST_IDX);
            end else if (accept) begin
                fft_valid <= 1'b0;
            end
            idx        <= idx_nxt;
            frame_done <= last_accept;
            if (start_ok) begin
                overrun <= 1'b0;
            end else if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_sample_feeder
//  Description : Self-checking bench for fft_sample_feeder (N_POINTS = 8)
//                against a behavioural frame/stream model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_sample_feeder;

    localparam int DW = 8;
    localparam int NP = 8;
    localparam int IW = 3;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          sample_clk = 1'b0;
    logic [DW-1:0] adc_data   = '0;
    logic          start      = 1'b0;
    logic          cont_mode  = 1'b0;
    logic          fft_ready  = 1'b0;
    logic          fft_valid;
    logic          fft_sop;
    logic          fft_eop;
    logic [DW-1:0] fft_data;
    logic          busy;
    logic          overrun;
    logic          frame_done;

    fft_sample_feeder #(.DW(DW), .N_POINTS(NP), .IDX_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_clk (sample_clk),
        .adc_data   (adc_data),
        .start      (start),
        .cont_mode  (cont_mode),
        .fft_ready  (fft_ready),
        .fft_valid  (fft_valid),
        .fft_sop    (fft_sop),
        .fft_eop    (fft_eop),
        .fft_data   (fft_data),
        .busy       (busy),
        .overrun    (overrun),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_run: 0 idle, 1 waiting for first tick, 2 streaming.
    int            m_run   = 0;
    bit            m_prev  = 1'b0;
    bit            m_held  = 1'b0;
    logic [DW-1:0] m_word  = '0;
    bit            m_first = 1'b0;
    bit            m_last  = 1'b0;
    int            m_sent  = 0;
    bit            m_ovr   = 1'b0;
    bit            m_done  = 1'b0;

    function automatic logic [DW-1:0] conv(input logic [DW-1:0] a);
`ifdef FFT_FEEDER_SIGNED_EN
        return DW'((int'(a) + (1 << (DW-1))) % (1 << DW));
`else
        return a;
`endif
    endfunction

    task automatic model_clear();
        m_run = 0; m_prev = 0; m_held = 0; m_word = '0; m_first = 0;
        m_last = 0; m_sent = 0; m_ovr = 0; m_done = 0;
    endtask

    task automatic model_step();
        bit edge_seen, taken, ending;
        int pos;
        edge_seen = sample_clk && !m_prev;
        m_prev    = sample_clk;
        taken     = m_held && fft_ready;
        pos       = taken ? (m_sent + 1) % NP : m_sent;
        ending    = taken && m_last && !cont_mode;
        m_done    = taken && m_last;
        if (m_run != 0 && edge_seen && m_held && !taken) m_ovr = 1;
        if (m_run != 0 && edge_seen && (!m_held || taken) && !ending) begin
            m_held  = 1;
            m_word  = conv(adc_data);
            m_first = (pos == 0);
            m_last  = (pos == NP - 1);
        end else if (taken) begin
            m_held = 0;
        end
        m_sent = pos;
        if (m_run == 0 && start) begin m_run = 1; m_ovr = 0; end
        else if (m_run == 1 && edge_seen) m_run = 2;
        else if (m_run == 2 && ending) m_run = 0;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_clear();
        else        model_step();
    end

    // ---------------- per-cycle compare + beat log ----------------
    typedef struct { logic [DW-1:0] d; logic s; logic e; } beat_t;
    beat_t beats[$];
    int    done_cnt = 0;

    initial forever begin
        @(negedge clk);
        chk("valid", fft_valid, m_held);
        chk("busy", busy, (m_run != 0));
        chk("overrun", overrun, m_ovr);
        chk("frame_done", frame_done, m_done);
        if (m_held) begin
            chk("data", fft_data, m_word);
            chk("sop", fft_sop, m_first);
            chk("eop", fft_eop, m_last);
        end
        if (fft_valid && fft_ready) beats.push_back('{fft_data, fft_sop, fft_eop});
        if (frame_done) done_cnt++;
    end

    // ---------------- stimulus ----------------
    int sper = 10;
    int phase = 0;
    int tick_num = 0;
    int dmode = 0;   // 0: tick number, 1: random, 2: alternating 80/00
    int busy_low = 0;

    task automatic cycle();
        @(posedge clk);
        #2;
        start = 1'b0;
        phase = (phase + 1) % sper;
        sample_clk = (phase < sper / 2);
        if (phase == 0) begin
            if (dmode == 1)      adc_data = DW'($urandom);
            else if (dmode == 2) adc_data = (tick_num % 2 == 0) ? 8'h80 : 8'h00;
            else                 adc_data = DW'(tick_num);
            tick_num++;
        end
    endtask

    task automatic new_sclk(input int per);
        sper = per; phase = per - 1; sample_clk = 1'b0; tick_num = 0;
    endtask

    task automatic run_until(input int n, input int budget, input int hook_d,
                             input int hook_len, input int cont_drop, input string name);
        int k = 0;
        bit hooked = 0;
        busy_low = 0;
        while (beats.size() < n && k < budget) begin
            cycle(); k++;
            if (!busy && beats.size() < n) busy_low = 1;
            if (cont_drop > 0 && beats.size() >= cont_drop) cont_mode = 1'b0;
            if (hook_len > 0 && !hooked && fft_valid && fft_data == DW'(hook_d)) begin
                hooked = 1; fft_ready = 1'b0;
                for (int j = 0; j < hook_len; j++) begin
                    cycle(); k++;
                    chk({name, "_hold_valid"}, fft_valid, 1);
                    chk({name, "_hold_data"}, fft_data, hook_d);
                end
                fft_ready = 1'b1;
            end
        end
        if (beats.size() < n) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got %0d beats, required %0d", name, beats.size(), n);
        end
    endtask

    task automatic check_seq(input string name, input int n);
        chk({name, "_count"}, beats.size(), n);
        for (int i = 0; i < n && i < beats.size(); i++) begin
            chk($sformatf("%s_data%0d", name, i), beats[i].d, i);
            chk($sformatf("%s_sop%0d", name, i), beats[i].s, (i % NP == 0));
            chk($sformatf("%s_eop%0d", name, i), beats[i].e, (i % NP == NP - 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", fft_valid, 0); chk("rst_sop", fft_sop, 0); chk("rst_eop", fft_eop, 0);
        chk("rst_data", fft_data, 0);   chk("rst_busy", busy, 0);   chk("rst_ovr", overrun, 0);
        chk("rst_done", frame_done, 0);
        rst_n = 1'b1;
        cycle();

        // Single frame
        beats.delete(); done_cnt = 0; cont_mode = 0; fft_ready = 1; dmode = 0;
        new_sclk(10); start = 1'b1;
        run_until(NP, 200, 0, 0, 0, "single");
        repeat (3) cycle();
        check_seq("single", NP);
        chk("single_done_cnt", done_cnt, 1);
        chk("single_busy_end", busy, 0);

        // Continuous mode, three frames
        beats.delete(); done_cnt = 0; cont_mode = 1;
        new_sclk(10); start = 1'b1;
        run_until(3 * NP, 600, 0, 0, 2 * NP + 1, "cont");
        chk("cont_busy_held", busy_low, 0);
        repeat (3) cycle();
        check_seq("cont", 3 * NP);
        chk("cont_done_cnt", done_cnt, 3);

        // Backpressure for 5 cycles on beat 3
        beats.delete(); cont_mode = 0;
        new_sclk(10); start = 1'b1;
        run_until(NP, 300, 3, 5, 0, "bp");
        repeat (3) cycle();
        check_seq("bp", NP);
        chk("bp_overrun", overrun, 0);

        // Overrun: ready low for 25 cycles on beat 2
        beats.delete();
        new_sclk(10); start = 1'b1;
        run_until(NP, 400, 2, 25, 0, "ovr");
        repeat (3) cycle();
        chk("ovr_count", beats.size(), NP);
        begin
            int exp_d[8] = '{0, 1, 2, 5, 6, 7, 8, 9};
            for (int i = 0; i < NP && i < beats.size(); i++) begin
                chk($sformatf("ovr_data%0d", i), beats[i].d, exp_d[i]);
                chk($sformatf("ovr_eop%0d", i), beats[i].e, (i == NP - 1));
            end
        end
        chk("ovr_sticky", overrun, 1);

        // Start clears overrun; then reset mid-frame at beat 4
        beats.delete();
        new_sclk(10); start = 1'b1;
        cycle();
        chk("ovr_cleared", overrun, 0);
        k = 0;
        while (!(fft_valid && fft_data == 8'd4) && k < 200) begin cycle(); k++; end
        chk("rst_mid_reached", (fft_valid && fft_data == 8'd4), 1);
        rst_n = 1'b0;
        #1;
        chk("rstm_valid", fft_valid, 0); chk("rstm_sop", fft_sop, 0); chk("rstm_eop", fft_eop, 0);
        chk("rstm_data", fft_data, 0);   chk("rstm_busy", busy, 0);   chk("rstm_done", frame_done, 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        beats.delete();
        new_sclk(10); start = 1'b1;
        run_until(NP, 200, 0, 0, 0, "fresh");
        repeat (3) cycle();
        check_seq("fresh", NP);

        // Offset-binary / two's complement mapping
        beats.delete(); dmode = 2;
        new_sclk(4); start = 1'b1;
        run_until(2, 100, 0, 0, 0, "sign");
`ifdef FFT_FEEDER_SIGNED_EN
        if (beats.size() >= 2) begin chk("sign_80", beats[0].d, 8'h00); chk("sign_00", beats[1].d, 8'h80); end
`else
        if (beats.size() >= 2) begin chk("sign_80", beats[0].d, 8'h80); chk("sign_00", beats[1].d, 8'h00); end
`endif
        run_until(NP, 100, 0, 0, 0, "sign_end");
        repeat (4) cycle();

        // Randomized traffic checked cycle by cycle against the model
        dmode = 1;
        for (int r = 0; r < 4; r++) begin
            new_sclk($urandom_range(2, 7));
            cont_mode = $urandom_range(0, 1);
            for (int c = 0; c < 400; c++) begin
                cycle();
                fft_ready = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 39) == 0) start = 1'b1;
                if ($urandom_range(0, 99) == 0) cont_mode = ~cont_mode;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_sample_feeder.md
Name: fft_sample_feeder

Overview:
- Consumer end of the divided sample clock. Detects each rising edge of `sample_clk` in the `clk` domain and captures the ADC word on that edge.
- Streams frames of exactly `N_POINTS` samples into the FFT core's sink interface using `valid`/`ready`/`sop`/`eop`.
- Sits between the sample-clock divider / ADC front end and the FFT core. Supports single-shot or continuous framing.

Parameters:
- `DW`, 8, ADC / FFT input data width in bits.
- `N_POINTS`, 1024, samples per frame; power of two, minimum 4.
- `IDX_W`, 10, sample index width; equals log2(`N_POINTS`).

Ports:
- `clk`  in  1  system clock; same clock that generates `sample_clk`.
- `rst_n`  in  1  asynchronous active-low reset.
- `sample_clk`  in  1  divided sample clock, registered in the `clk` domain.
- `adc_data`  in  `DW`  ADC sample word, stable around the `sample_clk` rising edge.
- `start`  in  1  one-cycle pulse; arms a capture.
- `cont_mode`  in  1  1 = re-arm automatically after `eop`; 0 = single frame.
- `fft_ready`  in  1  FFT sink ready.
- `fft_valid`  out  1  output sample valid.
- `fft_sop`  out  1  first sample of frame; qualified by `fft_valid`.
- `fft_eop`  out  1  last sample of frame; qualified by `fft_valid`.
- `fft_data`  out  `DW`  sample to FFT.
- `busy`  out  1  high in ARM or RUN.
- `overrun`  out  1  sticky; a tick arrived while a sample was still pending.
- `frame_done`  out  1  one-cycle pulse when the `eop` beat is accepted.

Behaviour:
- **Reset** (async, `rst_n` = 0). All outputs are 0 and state is IDLE. Internal state also clears: `idx` = 0, pending = 0, `sclk_d` = 0. Reset mid-frame discards the partial frame; no `eop` is emitted.
- **Tick generation.**
  - `sclk_d` <= `sample_clk` every cycle.
  - `tick` = `sample_clk` & ~`sclk_d`, giving one `clk` cycle per rising edge.
  - Falling edges are ignored.
- **States.**
  - IDLE: `start` -> ARM.
  - ARM: waits for the first `tick`, then -> RUN. That tick is captured as sample 0.
  - RUN: captures on each `tick`.
    - When the `eop` beat is accepted and `cont_mode` = 1, go to RUN with `idx` = 0. There is no gap; the next tick is sample 0.
    - When the `eop` beat is accepted and `cont_mode` = 0, go to IDLE.
  - `start` is ignored in ARM and RUN.
- **Capture (ARM or RUN, `tick`, pending = 0).**
  - `fft_data` <= `adc_data`. `fft_valid` rises on the next cycle, giving 1 `clk` latency from the cycle `tick` is asserted.
  - `fft_sop` = (`idx` == 0).
  - `fft_eop` = (`idx` == `N_POINTS`-1).
- **Handshake.**
  - A beat is accepted when `fft_valid` & `fft_ready`.
  - `fft_valid`, `fft_data`, `fft_sop` and `fft_eop` hold until the beat is accepted; this is the pending state.
  - On acceptance: `fft_valid` drops the next cycle, unless the same cycle is a new `tick`, in which case the new sample loads with `fft_valid` kept high. Then `idx` <= `idx`+1, wrapping to 0 after `N_POINTS`-1.
- **Overrun.** A `tick` with pending = 1 and no acceptance in the same cycle:
  - the new sample is discarded and `idx` does not advance, so every frame still carries exactly `N_POINTS` samples;
  - `overrun` <= 1, and it clears only on reset or on `start` accepted in IDLE.
- **`frame_done`**: one-cycle pulse in the cycle after the `eop` beat is accepted.
- **`busy`** = (state != IDLE).
- **`cont_mode`** is sampled only at the `eop` acceptance.

Optional Feature:
- Macro `FFT_FEEDER_SIGNED_EN`.
- Defined: `fft_data` = {~`adc_data`[`DW`-1], `adc_data`[`DW`-2:0]}. This converts offset-binary ADC output to two's complement for a signed FFT input.
- Undefined: `fft_data` = `adc_data` unchanged.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package `fft_pkg`:
  - state enum {IDLE, ARM, RUN};
  - default constants `FFT_DW` = 8, `FFT_N_POINTS` = 1024, `FFT_IDX_W` = 10.
- One sub-module, `sample_tick_gen`: the `sclk_d` register plus rising-edge detect, outputting `tick`. It is reusable by other consumers of `sample_clk`.
- FSM, index counter and output register stay in `fft_sample_feeder`.

Test Plan:
- **Single frame.** `N_POINTS` = 8, `fft_ready` = 1, `sample_clk` period 10 `clk`, `adc_data` = tick number 0..7, one `start` pulse.
  - Exactly 8 beats with data 0..7.
  - `sop` on data 0, `eop` on data 7.
  - `frame_done` pulses once, then IDLE and `busy` = 0.
- **Continuous mode.** `cont_mode` = 1, 3 frames.
  - `sop` lands on ticks 0, 8 and 16; `eop` on 7, 15 and 23.
  - No missed ticks; `busy` stays 1.
- **Backpressure.** `fft_ready` = 0 for 5 `clk` after beat 3, sample period 10.
  - Beat 3 data and `fft_valid` are held stable until accepted.
  - `overrun` stays 0.
- **Overrun.** `fft_ready` = 0 for 25 `clk` at beat 2, while ticks carry data 2, 3, 4.
  - Data 2 is delivered when ready returns; data 3 and 4 are dropped.
  - `overrun` = 1, and the next delivered sample is data 5 with `idx` 3.
  - The frame still ends with `eop` after 8 beats.
- **Reset mid-frame.** Assert `rst_n` = 0 at beat 4.
  - All outputs go to 0 immediately.
  - After release, a new `start` yields a fresh frame with `sop` on its first beat.
- **Signed conversion.** Macro defined, `adc_data` = 8'h80 -> `fft_data` = 8'h00; `adc_data` = 8'h00 -> 8'h80. Macro undefined -> data unchanged.
